max7219_display_ctrl: RTL

//  Sequences the MAX7219 LED driver for the clock: after reset it issues the configuration

---
 rtl/max7219_display_ctrl_pkg.sv | 19 +
 rtl/max7219_display_ctrl_if.sv | 16 +
 rtl/max7219_display_ctrl_spi_tx.sv | 78 +++++++
 rtl/max7219_display_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/max7219_display_ctrl_pkg.sv
// Register map, controller states and word packing for the MAX7219 display controller.
package max7219_display_ctrl_pkg;
  localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
  localparam logic [3:0] ADDR_DECODE       = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
  localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

  localparam int unsigned FRAME_HALVES = 34;
  localparam int unsigned NUM_INIT     = 5;
  localparam int unsigned NUM_DIGITS   = 8;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_INTENS, ST_DIGITS} ctrl_state_t;

  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction
endpackage

// File: rtl/max7219_display_ctrl_if.sv
// Host-side request/status signals and the MAX7219 serial pins.
interface max7219_display_ctrl_if;
  logic        i_refresh;
  logic [63:0] i_digits;
  logic [3:0]  i_intensity;
  logic        o_busy;
  logic        o_init_done;
  logic        o_serial_din;
  logic        o_serial_load;
  logic        o_serial_clk;

  modport master (output i_refresh, i_digits, i_intensity,
                  input  o_busy, o_init_done, o_serial_din, o_serial_load, o_serial_clk);
  modport slave  (input  i_refresh, i_digits, i_intensity,
                  output o_busy, o_init_done, o_serial_din, o_serial_load, o_serial_clk);
endinterface

// File: rtl/max7219_display_ctrl_spi_tx.sv
// Serialises one 16-bit MAX7219 word: 16 clocked bits, LOAD rise, then a LOAD-high gap.
module max7219_spi_tx
  import max7219_display_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [15:0] i_word,
  output logic        o_active,
  output logic        o_done,
  output logic        o_serial_din,
  output logic        o_serial_load,
  output logic        o_serial_clk
);
  localparam int unsigned     DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]      HALF_TAIL  = 6'(FRAME_HALVES - 2);
  localparam logic [5:0]      HALF_GAP   = 6'(FRAME_HALVES - 1);

  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_half;
  logic [15:0]      r_shift;
  logic             r_active, r_din, r_load, r_sclk;
  logic             w_half_end, w_done;
  logic [5:0]       w_half_nxt;

  assign w_half_end = r_active && (r_div == DIV_LAST);
  assign w_done     = w_half_end && (r_half == HALF_GAP);
  assign w_half_nxt = r_half + 6'd1;

  // Half-period index: even = SCLK low, odd = SCLK high; then tail-low and LOAD-high gap.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_half   <= '0;
      r_shift  <= '0;
      r_din    <= 1'b0;
      r_load   <= 1'b1;
      r_sclk   <= 1'b0;
    end else if (i_start && (!r_active || w_done)) begin
      r_active <= 1'b1;
      r_div    <= '0;
      r_half   <= '0;
      r_shift  <= i_word;
      r_din    <= i_word[15];
      r_load   <= 1'b0;
      r_sclk   <= 1'b0;
    end else if (w_done) begin
      r_active <= 1'b0;
      r_din    <= 1'b0;
    end else if (r_active) begin
      r_div <= w_half_end ? '0 : r_div + DIV_W'(1);
      if (w_half_end) begin
        r_half <= w_half_nxt;
        if (w_half_nxt == HALF_GAP) begin
          r_load <= 1'b1;
        end else if (w_half_nxt == HALF_TAIL) begin
          r_sclk <= 1'b0;
        end else begin
          r_sclk <= w_half_nxt[0];
          if (!w_half_nxt[0]) begin
            r_din   <= r_shift[14];
            r_shift <= {r_shift[14:0], 1'b0};
          end
        end
      end
    end
  end

  assign o_active      = r_active;
  assign o_done        = w_done;
  assign o_serial_din  = r_din;
  assign o_serial_load = r_load;
  assign o_serial_clk  = r_sclk;
endmodule

// File: rtl/max7219_display_ctrl.sv
// MAX7219 sequencer: config words after reset, then all eight digits on each refresh.
//   state  | meaning
//   INIT   | sending the five configuration words
//   IDLE   | waiting for a refresh request
//   INTENS | intensity word in flight ahead of the digits
//   DIGITS | digit words 0..7 in flight
module max7219_display_ctrl
  import max7219_display_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter logic [7:0]  DECODE_MASK = 8'hFF,
  parameter logic [2:0]  SCAN_LIMIT  = 3'd7
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  max7219_display_ctrl_if.slave  bus
);
  ctrl_state_t r_state, w_state_nxt;
  logic [2:0]  r_idx, w_idx_nxt, w_idx_inc;
  logic [63:0] r_digits;
  logic [3:0]  r_last_int;
  logic        r_pending, r_init_done;
  logic        w_start, w_accept, w_seq_end, w_req, w_int_wr;
  logic [15:0] w_word;
  logic        w_tx_active, w_tx_done, w_tx_load;

  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
    case (idx)
      3'd0:    return make_word(ADDR_DISPLAY_TEST, 8'h00);
      3'd1:    return make_word(ADDR_SCAN_LIMIT, {5'd0, SCAN_LIMIT});
      3'd2:    return make_word(ADDR_DECODE, DECODE_MASK);
      3'd3:    return make_word(ADDR_INTENSITY, {4'h0, intensity});
      default: return make_word(ADDR_SHUTDOWN, 8'h01);
    endcase
  endfunction

  assign w_idx_inc = r_idx + 3'd1;
  assign w_req     = r_pending | bus.i_refresh;
  assign w_int_wr  = w_start && (w_word[11:8] == ADDR_INTENSITY);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_start     = 1'b0;
    w_word      = '0;
    w_accept    = 1'b0;
    w_seq_end   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (!w_tx_active) begin
          w_start = 1'b1;
          w_word  = init_word(3'd0, bus.i_intensity);
        end else if (w_tx_done) begin
          if (r_idx == 3'(NUM_INIT - 1)) begin
            w_seq_end = 1'b1;
          end else begin
            w_start   = 1'b1;
            w_idx_nxt = w_idx_inc;
            w_word    = init_word(w_idx_inc, bus.i_intensity);
          end
        end
      end
      ST_IDLE: w_seq_end = 1'b1;
      ST_INTENS: begin
        if (w_tx_done) begin
          w_start     = 1'b1;
          w_word      = make_word(ADDR_DIGIT0, r_digits[7:0]);
          w_state_nxt = ST_DIGITS;
          w_idx_nxt   = '0;
        end
      end
      ST_DIGITS: begin
        if (w_tx_done) begin
          if (r_idx == 3'(NUM_DIGITS - 1)) begin
            w_seq_end = 1'b1;
          end else begin
            w_start   = 1'b1;
            w_idx_nxt = w_idx_inc;
            w_word    = make_word(ADDR_DIGIT0 + {1'b0, w_idx_inc}, r_digits[{w_idx_inc, 3'b000} +: 8]);
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase

    // A finished sequence chains straight into a waiting request, reading live inputs.
    if (w_seq_end) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      if (w_req) begin
        w_accept = 1'b1;
        w_start  = 1'b1;
        if (bus.i_intensity != r_last_int) begin
          w_word      = make_word(ADDR_INTENSITY, {4'h0, bus.i_intensity});
          w_state_nxt = ST_INTENS;
        end else begin
          w_word      = make_word(ADDR_DIGIT0, bus.i_digits[7:0]);
          w_state_nxt = ST_DIGITS;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_INIT;
      r_idx       <= '0;
      r_digits    <= '0;
      r_last_int  <= '0;
      r_pending   <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pending <= w_accept ? 1'b0 : (r_pending | bus.i_refresh);
      if (w_accept) r_digits <= bus.i_digits;
      if (w_int_wr) r_last_int <= w_word[3:0];
      if ((r_state == ST_INIT) && (r_idx == 3'(NUM_INIT - 1)) && w_tx_active && w_tx_load)
        r_init_done <= 1'b1;
    end
  end

  max7219_spi_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_start       (w_start),
    .i_word        (w_word),
    .o_active      (w_tx_active),
    .o_done        (w_tx_done),
    .o_serial_din  (bus.o_serial_din),
    .o_serial_load (w_tx_load),
    .o_serial_clk  (bus.o_serial_clk)
  );

  assign bus.o_serial_load = w_tx_load;
  assign bus.o_busy        = (r_state != ST_IDLE);
  assign bus.o_init_done   = r_init_done;
endmodule
